// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit a+b+cin split into STAGES carry chunks, one
// chunk resolved per register stage, valid/ready on both sides with
// collapsing bubbles. Stage k registers the sum of chunks 0..k, the
// still-unprocessed operand bits and the carry out of chunk k.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_param
        $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    // Index k is the input of stage k; index STAGES is the output side.
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][WIDTH-1:0] a_pipe;
    logic [STAGES:0][WIDTH-1:0] b_pipe;
    logic [STAGES:0][WIDTH-1:0] sum_pipe;
    logic [STAGES:0]            c_pipe;
    logic [STAGES:0]            adv;
    logic                       msbc_q;

    assign vld_pipe[0] = in_valid;
    assign a_pipe[0]   = a;
    assign b_pipe[0]   = b;
    assign sum_pipe[0] = '0;
    assign c_pipe[0]   = cin;

    // Advance chain from the consumer back to the producer: an empty stage
    // always advances, so bubbles collapse even while the output stalls.
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !vld_pipe[k+1] || adv[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vld_q;
        logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
        logic             c_q, c_d;
        logic [CHUNK:0]   add;

        // Resolve chunk k using the carry handed over from the previous stage.
        always_comb begin
            add   = {1'b0, a_pipe[k][k*CHUNK +: CHUNK]}
                  + {1'b0, b_pipe[k][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, c_pipe[k]};
            sum_d = sum_pipe[k];
            sum_d[k*CHUNK +: CHUNK] = add[CHUNK-1:0];
            c_d   = add[CHUNK];
        end

        // Stage register: load from upstream when advancing, else hold.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (adv[k]) begin
                vld_q <= vld_pipe[k];
                a_q   <= a_pipe[k];
                b_q   <= b_pipe[k];
                sum_q <= sum_d;
                c_q   <= c_d;
            end
        end

        assign vld_pipe[k+1] = vld_q;
        assign a_pipe[k+1]   = a_q;
        assign b_pipe[k+1]   = b_q;
        assign sum_pipe[k+1] = sum_q;
        assign c_pipe[k+1]   = c_q;

        if (k == STAGES - 1) begin : g_msb
            // Carry into the MSB, recovered as a ^ b ^ sum at bit WIDTH-1.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    msbc_q <= 1'b0;
                end else if (adv[k]) begin
                    msbc_q <= a_pipe[k][WIDTH-1] ^ b_pipe[k][WIDTH-1] ^ add[CHUNK-1];
                end
            end
        end
    end

    // Consumed operand bits and overwritten sum chunks are dead by design.
    logic unused_bits;
    assign unused_bits = ^{a_pipe, b_pipe, sum_pipe};

    assign in_ready  = adv[0];
    assign out_valid = vld_pipe[STAGES];
    assign sum       = sum_pipe[STAGES];
    assign cout      = c_pipe[STAGES];
    assign overflow  = c_pipe[STAGES] ^ msbc_q;
endmodule
